// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one memory request/response port between
// NumPorts load store units. Requests pass through one output register.
// Responses are steered back by the port index carried in the top id bits.

// Per-port slice: grant decode for this port and its registered response valid.
module lsu_arb_lane #(
    parameter int Lane         = 0,
    parameter int PortIdxWidth = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    accept,
    input  logic                    gnt_valid,
    input  logic [PortIdxWidth-1:0] gnt_idx,
    input  logic                    rsp_valid,
    input  logic [PortIdxWidth-1:0] rsp_port,
    output logic                    ready,
    output logic                    rsp_valid_q
);
    assign ready = accept & gnt_valid & (gnt_idx == PortIdxWidth'(Lane));

    // Response valid for this port, one cycle after the memory response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rsp_valid_q <= 1'b0;
        else       rsp_valid_q <= rsp_valid & (rsp_port == PortIdxWidth'(Lane));
    end
endmodule

module lsu_mem_arbiter #(
    parameter  int NumPorts       = 4,
    parameter  int AddressWidth   = 32,
    parameter  int BlockIdxBits   = 4,
    parameter  int ReqIdWidth     = 5,
    localparam int BlockWidth     = 1 << BlockIdxBits,
    localparam int PortIdxWidth   = NumPorts > 1 ? $clog2(NumPorts) : 1,
    localparam int BlockAddrWidth = AddressWidth - BlockIdxBits,
    localparam int MemIdWidth     = ReqIdWidth + PortIdxWidth
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [NumPorts-1:0]                        port_req_valid_i,
    output logic [NumPorts-1:0]                        port_ready_o,
    input  logic [NumPorts-1:0][ReqIdWidth-1:0]        port_req_id_i,
    input  logic [NumPorts-1:0][BlockAddrWidth-1:0]    port_req_addr_i,
    input  logic [NumPorts-1:0][BlockWidth-1:0]        port_req_we_mask_i,
    input  logic [NumPorts-1:0][8*BlockWidth-1:0]      port_req_wdata_i,
    input  logic                                       mem_ready_i,
    output logic                                       mem_req_valid_o,
    output logic [MemIdWidth-1:0]                      mem_req_id_o,
    output logic [BlockAddrWidth-1:0]                  mem_req_addr_o,
    output logic [BlockWidth-1:0]                      mem_req_we_mask_o,
    output logic [8*BlockWidth-1:0]                    mem_req_wdata_o,
    input  logic                                       mem_rsp_valid_i,
    input  logic [MemIdWidth-1:0]                      mem_rsp_id_i,
    input  logic [8*BlockWidth-1:0]                    mem_rsp_data_i,
    output logic [NumPorts-1:0]                        port_rsp_valid_o,
    output logic [ReqIdWidth-1:0]                      port_rsp_id_o,
    output logic [8*BlockWidth-1:0]                    port_rsp_data_o,
    output logic                                       err_o
);
    typedef struct packed {
        logic [MemIdWidth-1:0]     id;
        logic [BlockAddrWidth-1:0] addr;
        logic [BlockWidth-1:0]     we_mask;
        logic [8*BlockWidth-1:0]   wdata;
    } mem_req_t;

    mem_req_t                req_q;
    logic                    req_vld_q;
    logic [PortIdxWidth-1:0] ptr_q;
    logic                    accept;
    logic                    gnt_valid;
    logic [PortIdxWidth-1:0] gnt_idx;
    logic [PortIdxWidth:0]   k;
    logic [PortIdxWidth-1:0] rsp_port;
    logic                    rsp_bad;
    logic [ReqIdWidth-1:0]   rsp_id_q;
    logic [8*BlockWidth-1:0] rsp_data_q;
    logic                    err_q;

    // Register takes a new request when empty or draining this cycle; ready is held low in reset.
    assign accept = (~req_vld_q | mem_ready_i) & ~rst_i;

    // First valid port at or after the pointer, wrapping at NumPorts.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        k         = '0;
        for (int i = 0; i < NumPorts; i++) begin
            k = {1'b0, ptr_q} + (PortIdxWidth+1)'(i);
            if (k >= (PortIdxWidth+1)'(NumPorts)) k = k - (PortIdxWidth+1)'(NumPorts);
            if (!gnt_valid && port_req_valid_i[k[PortIdxWidth-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = k[PortIdxWidth-1:0];
            end
        end
    end

    assign rsp_port = mem_rsp_id_i[MemIdWidth-1 -: PortIdxWidth];
    assign rsp_bad  = mem_rsp_valid_i & (int'(rsp_port) >= NumPorts);

    for (genvar p = 0; p < NumPorts; p++) begin : g_lane
        lsu_arb_lane #(.Lane(p), .PortIdxWidth(PortIdxWidth)) u_lane (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .accept      (accept),
            .gnt_valid   (gnt_valid),
            .gnt_idx     (gnt_idx),
            .rsp_valid   (mem_rsp_valid_i),
            .rsp_port    (rsp_port),
            .ready       (port_ready_o[p]),
            .rsp_valid_q (port_rsp_valid_o[p])
        );
    end

    // Output register and round-robin pointer; both hold while memory stalls a full register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q     <= '0;
            req_vld_q <= 1'b0;
            ptr_q     <= '0;
        end else if (accept) begin
            req_vld_q <= gnt_valid;
            if (gnt_valid) begin
                req_q.id      <= {gnt_idx, port_req_id_i[gnt_idx]};
                req_q.addr    <= port_req_addr_i[gnt_idx];
                req_q.we_mask <= port_req_we_mask_i[gnt_idx];
                req_q.wdata   <= port_req_wdata_i[gnt_idx];
                if (gnt_idx == PortIdxWidth'(NumPorts-1)) ptr_q <= '0;
                else                                      ptr_q <= gnt_idx + PortIdxWidth'(1);
            end
        end
    end

    // Shared response id/data plus sticky error for responses naming a nonexistent port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (mem_rsp_valid_i) begin
                rsp_id_q   <= mem_rsp_id_i[ReqIdWidth-1:0];
                rsp_data_q <= mem_rsp_data_i;
            end
            if (rsp_bad) err_q <= 1'b1;
        end
    end

    assign mem_req_valid_o   = req_vld_q;
    assign mem_req_id_o      = req_q.id;
    assign mem_req_addr_o    = req_q.addr;
    assign mem_req_we_mask_o = req_q.we_mask;
    assign mem_req_wdata_o   = req_q.wdata;
    assign port_rsp_id_o     = rsp_id_q;
    assign port_rsp_data_o   = rsp_data_q;
    assign err_o             = err_q;
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: a 4-port instance checked every cycle against a
// queue-free behavioural model, plus a 3-port instance for wrap and bad-index cases.
module tb_lsu_mem_arbiter;
    localparam int N = 4, RIW = 5, BAW = 28, BW = 16, MIW = 7, DW = 128;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]           req_valid, ready, rsp_vld_o;
    logic [N-1:0][RIW-1:0]  req_id;
    logic [N-1:0][BAW-1:0]  req_addr;
    logic [N-1:0][BW-1:0]   req_mask;
    logic [N-1:0][DW-1:0]   req_wdata;
    logic                   mem_ready, mreq_vld, rsp_vld_i, err;
    logic [MIW-1:0]         mreq_id, rsp_id_i;
    logic [BAW-1:0]         mreq_addr;
    logic [BW-1:0]          mreq_mask;
    logic [DW-1:0]          mreq_wdata, rsp_data_i, rsp_data_o;
    logic [RIW-1:0]         rsp_id_o;

    logic [N3-1:0]          req3_valid, ready3, rsp3_vld_o;
    logic [N3-1:0][RIW-1:0] req3_id;
    logic [N3-1:0][BAW-1:0] req3_addr;
    logic [N3-1:0][BW-1:0]  req3_mask;
    logic [N3-1:0][DW-1:0]  req3_wdata;
    logic                   mem3_ready, mreq3_vld, rsp3_vld_i, err3;
    logic [MIW-1:0]         mreq3_id, rsp3_id_i;
    logic [BAW-1:0]         mreq3_addr;
    logic [BW-1:0]          mreq3_mask;
    logic [DW-1:0]          mreq3_wdata, rsp3_data_i, rsp3_data_o;
    logic [RIW-1:0]         rsp3_id_o;

    lsu_mem_arbiter #(.NumPorts(N)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .port_req_valid_i(req_valid), .port_ready_o(ready),
        .port_req_id_i(req_id), .port_req_addr_i(req_addr),
        .port_req_we_mask_i(req_mask), .port_req_wdata_i(req_wdata),
        .mem_ready_i(mem_ready), .mem_req_valid_o(mreq_vld), .mem_req_id_o(mreq_id),
        .mem_req_addr_o(mreq_addr), .mem_req_we_mask_o(mreq_mask), .mem_req_wdata_o(mreq_wdata),
        .mem_rsp_valid_i(rsp_vld_i), .mem_rsp_id_i(rsp_id_i), .mem_rsp_data_i(rsp_data_i),
        .port_rsp_valid_o(rsp_vld_o), .port_rsp_id_o(rsp_id_o), .port_rsp_data_o(rsp_data_o),
        .err_o(err)
    );

    lsu_mem_arbiter #(.NumPorts(N3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .port_req_valid_i(req3_valid), .port_ready_o(ready3),
        .port_req_id_i(req3_id), .port_req_addr_i(req3_addr),
        .port_req_we_mask_i(req3_mask), .port_req_wdata_i(req3_wdata),
        .mem_ready_i(mem3_ready), .mem_req_valid_o(mreq3_vld), .mem_req_id_o(mreq3_id),
        .mem_req_addr_o(mreq3_addr), .mem_req_we_mask_o(mreq3_mask), .mem_req_wdata_o(mreq3_wdata),
        .mem_rsp_valid_i(rsp3_vld_i), .mem_rsp_id_i(rsp3_id_i), .mem_rsp_data_i(rsp3_data_i),
        .port_rsp_valid_o(rsp3_vld_o), .port_rsp_id_o(rsp3_id_o), .port_rsp_data_o(rsp3_data_o),
        .err_o(err3)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: what the memory side should currently show, the rotation
    // pointer, and the response expected to appear this cycle.
    int             m_ptr, r_port;
    bit             m_vld, r_vld, m_err;
    logic [MIW-1:0] m_id;
    logic [BAW-1:0] m_addr;
    logic [BW-1:0]  m_mask;
    logic [DW-1:0]  m_wdata, r_data;
    logic [RIW-1:0] r_id;

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_err = 0; r_vld = 0; r_port = 0;
        m_id = '0; m_addr = '0; m_mask = '0; m_wdata = '0; r_id = '0; r_data = '0;
    endtask

    // One clock: check everything at the falling edge, then advance the model at the rising edge.
    task automatic cycle();
        int g;
        bit acc;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        chk("mem_req_valid", mreq_vld, m_vld);
        if (m_vld) begin
            chk("mem_req_id", mreq_id, m_id);
            chk("mem_req_addr", mreq_addr, m_addr);
            chk("mem_req_mask", mreq_mask, m_mask);
            chk("mem_req_wdata", mreq_wdata, m_wdata);
        end
        acc = !m_vld || mem_ready;
        g = -1;
        for (int i = 0; i < N; i++)
            if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        exp_rdy = (acc && g >= 0) ? N'(1 << g) : '0;
        chk("port_ready", ready, exp_rdy);
        chk("port_rsp_valid", rsp_vld_o, r_vld ? (1 << r_port) : 0);
        if (r_vld) begin
            chk("port_rsp_id", rsp_id_o, r_id);
            chk("port_rsp_data", rsp_data_o, r_data);
        end
        chk("err", err, m_err);
        @(posedge clk);
        if (acc) begin
            m_vld = (g >= 0);
            if (g >= 0) begin
                m_id    = {g[1:0], req_id[g]};
                m_addr  = req_addr[g];
                m_mask  = req_mask[g];
                m_wdata = req_wdata[g];
                m_ptr   = (g + 1) % N;
            end
        end
        r_vld  = rsp_vld_i;
        r_port = int'(rsp_id_i[MIW-1:RIW]);
        r_id   = rsp_id_i[RIW-1:0];
        r_data = rsp_data_i;
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_id = '0; req_addr = '0; req_mask = '0; req_wdata = '0;
        mem_ready = 1'b0; rsp_vld_i = 1'b0; rsp_id_i = '0; rsp_data_i = '0;
        req3_valid = '0; req3_id = '0; req3_addr = '0; req3_mask = '0; req3_wdata = '0;
        mem3_ready = 1'b0; rsp3_vld_i = 1'b0; rsp3_id_i = '0; rsp3_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mem_vld", mreq_vld, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rsp_vld", rsp_vld_o, 0);
        chk("rst_err", err, 0);
        chk("rst_err3", err3, 0);
    endtask

    task automatic fill_port(input int p);
        req_id[p]    = RIW'($urandom);
        req_addr[p]  = BAW'($urandom);
        req_mask[p]  = BW'($urandom);
        req_wdata[p] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic [DW-1:0] aa;
        int order [6];
        aa = {16{8'hAA}};
        order = '{0, 1, 2, 3, 0, 1};
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // 3-port instance: routing, wrap of the rotation at 3, sticky bad-index error.
        rsp3_vld_i = 1'b1; rsp3_id_i = {2'd2, 5'd9}; rsp3_data_i = 128'h1234;
        @(posedge clk); #1 rsp3_vld_i = 1'b0;
        chk("p3_rsp_vld", rsp3_vld_o, 3'b100);
        chk("p3_rsp_id", rsp3_id_o, 5'd9);
        chk("p3_err_clear", err3, 0);
        rsp3_vld_i = 1'b1; rsp3_id_i = {2'd3, 5'd1};
        @(posedge clk); #1 rsp3_vld_i = 1'b0;
        chk("p3_bad_rsp_vld", rsp3_vld_o, 3'b000);
        chk("p3_err_set", err3, 1);
        repeat (3) @(posedge clk);
        #1 chk("p3_err_sticky", err3, 1);
        req3_valid = 3'b101; mem3_ready = 1'b1;
        #1 chk("p3_gnt0", ready3, 3'b001);
        @(posedge clk); #1 chk("p3_gnt2", ready3, 3'b100);
        @(posedge clk); #1 chk("p3_gnt_wrap", ready3, 3'b001);
        do_reset();

        // Single request from port 0.
        req_valid = 4'b0001; req_id[0] = 5'd5; req_addr[0] = 28'h123; mem_ready = 1'b1;
        #1 chk("t1_ready", ready, 4'b0001);
        cycle();
        req_valid = '0;
        #1 chk("t1_mem_vld", mreq_vld, 1);
        chk("t1_addr", mreq_addr, 28'h123);
        chk("t1_id", mreq_id, {2'd0, 5'd5});
        cycle();

        // All ports requesting: strict rotation, one per cycle.
        do_reset();
        req_valid = 4'b1111; mem_ready = 1'b1;
        for (int p = 0; p < N; p++) fill_port(p);
        for (int i = 0; i < 6; i++) begin
            #1 chk("t2_order", ready, 1 << order[i]);
            cycle();
        end

        // Stall with a full register, then release.
        do_reset();
        req_valid = 4'b0010; mem_ready = 1'b1;
        cycle();
        req_valid = 4'b1111; mem_ready = 1'b0;
        repeat (3) cycle();
        mem_ready = 1'b1;
        #1 chk("t3_next_after_stall", ready, 4'b0100);
        cycle();
        cycle();

        // Response routing to port 2.
        req_valid = '0;
        rsp_vld_i = 1'b1; rsp_id_i = {2'd2, 5'd7}; rsp_data_i = aa;
        cycle();
        rsp_vld_i = 1'b0;
        #1 chk("t4_rsp_vld", rsp_vld_o, 4'b0100);
        chk("t4_rsp_id", rsp_id_o, 5'd7);
        chk("t4_rsp_data", rsp_data_o, aa);
        cycle();

        // Randomised traffic on both paths.
        for (int c = 0; c < 400; c++) begin
            req_valid = N'($urandom);
            for (int p = 0; p < N; p++) if ($urandom_range(0, 1) == 1) fill_port(p);
            mem_ready  = ($urandom_range(0, 3) != 0);
            rsp_vld_i  = ($urandom_range(0, 1) == 1);
            rsp_id_i   = MIW'($urandom);
            rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // Asynchronous reset in the middle of a stall after port 1 was granted.
        do_reset();
        req_valid = 4'b0010; mem_ready = 1'b1;
        for (int p = 0; p < N; p++) fill_port(p);
        cycle();
        req_valid = 4'b1111; mem_ready = 1'b0;
        rsp_vld_i = 1'b1; rsp_id_i = {2'd1, 5'd3};
        cycle();
        rsp_vld_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_mem_vld", mreq_vld, 0);
        chk("t6_mem_id", mreq_id, 0);
        chk("t6_mem_addr", mreq_addr, 0);
        chk("t6_ready", ready, 0);
        chk("t6_rsp_vld", rsp_vld_o, 0);
        chk("t6_err", err, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        mem_ready = 1'b1;
        #1 chk("t6_first_gnt", ready, 4'b0001);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
